march_ctrl: RTL and testbench
=============================

# march_ctrl

March C- sequencer for the MBIST engine. It sits directly upstream of the address `counter`, driving its `ld`/`cen`/`u_d`/`d_in` and reading back its `q` as the current address. It also drives the memory-under-test's enable, write-enable and write data, compares read data against the expected background, and reports pass/fail with the first failing address.

## Interface
- `ADDR_W`, default 10: address width. Matches the counter's `LENGTH`. Memory depth N = 2^ADDR_W.
- `DATA_W`, default 8: memory word width. Backgrounds are all-zeros or all-ones.

- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a test. Sampled only in IDLE or DONE.
- `addr` in ADDR_W: counter `q`. This is also the memory address.
- `mem_rdata` in DATA_W: memory read data, valid one cycle after a read is issued.
- `ld` out 1: counter load. Asserted only together with `cen`.
- `cen` out 1: counter enable.
- `u_d` out 1: counter direction. 1 = up, 0 = down.
- `d_in` out ADDR_W: counter load value.
- `mem_en` out 1: memory access this cycle.
- `mem_we` out 1: 1 = write, 0 = read. Meaningful only with `mem_en`.
- `mem_wdata` out DATA_W: write background.
- `busy` out 1: test in progress.
- `done` out 1: level. High in DONE until the next accepted `start`.
- `fail` out 1: sticky mismatch flag.
- `fail_addr` out ADDR_W: address of the first mismatch.

## Operation
- Elements, indexed 0–5:
  - E0 ⇑(w0)
  - E1 ⇑(r0,w1)
  - E2 ⇑(r1,w0)
  - E3 ⇓(r0,w1)
  - E4 ⇓(r1,w0)
  - E5 ⇑(r0)
- "0" = all-zeros word, "1" = all-ones word.
- States: IDLE, LOAD, OP0, OP1, FLUSH, DONE.
- IDLE/DONE with `start`=1 → LOAD(E0). On this transition `fail`, `fail_addr` and `done` clear.
- LOAD, one cycle:
  - `ld`=1, `cen`=1, `u_d` = element direction.
  - `d_in` = 0 for ⇑ elements, all-ones for ⇓ elements.
  - `mem_en`=0.
  - Next state is OP0.
- OP0: first operation of the element at `addr`.
  - If the element has two operations, go to OP1.
  - Otherwise, this is the last operation at this address (see below).
- OP1: second operation at `addr`. This is the last operation at this address.
- Last operation at an address:
  - If `addr` is not the terminal address (all-ones for ⇑, 0 for ⇓): `cen`=1, `ld`=0, `u_d` = direction, next state OP0.
  - If `addr` is terminal: `cen`=0 (the counter never wraps), next state is LOAD of the next element, or FLUSH after E5.
- `cen`=0 in every OP cycle that is not the last operation at its address.
- FLUSH: one cycle with no memory access. It lets the final E5 read compare. Next state is DONE.
- Read compare:
  - On a read issue, register `rd_pending`, the expected background and `addr`.
  - In the next cycle, if `rd_pending` and `mem_rdata` ≠ expected, set `fail`=1.
  - `fail_addr` loads only when `fail` was 0, so it keeps the first failure.
  - The test always runs to completion.
- `start` while `busy`: ignored.
- `counter` `cout` is not used; terminal detection uses `addr` only.

## Timing
- Outputs are Moore-decoded from the state and element registers. `fail` and `fail_addr` are registered.
- Reset values: state IDLE, element 0, `rd_pending`=0; all outputs 0, including `d_in`, `mem_wdata` and `fail_addr`.
- Reset mid-test: immediate return to IDLE. Any pending compare is discarded and `fail` is cleared.
- Cycle count: the edge that samples `start` enters LOAD. `busy` is then high for 6 + 10·N + 1 cycles (LOAD×6, OPs, FLUSH). `done` rises on the following edge.
- Counter handshake:
  - The value loaded in LOAD appears on `addr` in the first OP0 cycle.
  - An increment or decrement on the last operation is visible in the next OP0.
- Write data: `mem_wdata` equals the background of the current operation when `mem_we`=1, and 0 otherwise.

## Test plan
- Reset, then idle: all outputs 0. `start` held low for 20 cycles → state unchanged, `busy`=0.
- ADDR_W=2 fault-free memory model, `start` pulse:
  - `busy` high exactly 47 cycles, then `done`=1, `fail`=0.
  - Logged access sequence matches March C- order, e.g. E3 visits addresses 3,2,1,0.
- Stuck-at-1 on bit 0 of address 2 → `fail`=1 at the E1 r0 compare of address 2, `fail_addr`=2, `done` still after 47 cycles.
- Stuck-at-0 on all bits of address 3 → first mismatch at E2 r1 of address 3, `fail_addr`=3. A later E4 mismatch must not change `fail_addr`.
- `start` pulsed mid-test → ignored. Then assert `rst` in E3 → all outputs 0 immediately, no stale compare. A new `start` runs a clean 47-cycle pass.
- Counter interface check with the real `counter` (LENGTH=10):
  - `ld`=1 only with `cen`=1.
  - `addr` never wraps.
  - Total `busy` = 10247 cycles.

Source files
------------

// File: rtl/march_ctrl.sv
// March C- sequencer for the MBIST engine: steers an external address counter,
// drives the memory under test and checks read data against the expected background.
module march_ctrl #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              ld_o,
  output logic              cen_o,
  output logic              u_d_o,
  output logic [ADDR_W-1:0] d_in_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              fail_o,
  output logic [ADDR_W-1:0] fail_addr_o
);

  typedef enum logic [2:0] {IDLE, LOAD, OP0, OP1, FLUSH, DONE} state_t;

  state_t              state_q, state_d;
  logic [2:0]          elem_q, elem_d;
  logic                rd_pending_q, rd_pending_d;
  logic [DATA_W-1:0]   rd_exp_q, rd_exp_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                fail_q, fail_d;
  logic [ADDR_W-1:0]   fail_addr_q, fail_addr_d;

  logic elem_up, two_ops, op_we, op_bg, terminal, accept;

  // Element table: direction, operation count, and the write/background of the current op.
  always_comb begin
    elem_up = 1'b1;
    two_ops = 1'b0;
    op_we   = 1'b0;
    op_bg   = 1'b0;
    case (elem_q)
      3'd0: op_we = 1'b1;
      3'd1: begin two_ops = 1'b1; op_we = (state_q == OP1); op_bg = (state_q == OP1); end
      3'd2: begin two_ops = 1'b1; op_we = (state_q == OP1); op_bg = (state_q != OP1); end
      3'd3: begin elem_up = 1'b0; two_ops = 1'b1; op_we = (state_q == OP1); op_bg = (state_q == OP1); end
      3'd4: begin elem_up = 1'b0; two_ops = 1'b1; op_we = (state_q == OP1); op_bg = (state_q != OP1); end
      default: ;
    endcase
  end

  assign terminal = elem_up ? (&addr_i) : ~(|addr_i);
  assign accept   = ((state_q == IDLE) || (state_q == DONE)) && start_i;

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    ld_o        = 1'b0;
    cen_o       = 1'b0;
    u_d_o       = 1'b0;
    d_in_o      = '0;
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = '0;
    busy_o      = 1'b0;
    done_o      = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        done_o = (state_q == DONE);
        if (start_i) begin
          state_d = LOAD;
          elem_d  = 3'd0;
        end
      end
      LOAD: begin
        busy_o  = 1'b1;
        ld_o    = 1'b1;
        cen_o   = 1'b1;
        u_d_o   = elem_up;
        d_in_o  = elem_up ? '0 : {ADDR_W{1'b1}};
        state_d = OP0;
      end
      OP0, OP1: begin
        busy_o      = 1'b1;
        mem_en_o    = 1'b1;
        mem_we_o    = op_we;
        mem_wdata_o = op_we ? {DATA_W{op_bg}} : '0;
        // The counter is only stepped on the last op at an address and never past the end.
        if ((state_q == OP0) && two_ops) begin
          state_d = OP1;
        end else if (!terminal) begin
          cen_o   = 1'b1;
          u_d_o   = elem_up;
          state_d = OP0;
        end else if (elem_q == 3'd5) begin
          state_d = FLUSH;
        end else begin
          elem_d  = elem_q + 3'd1;
          state_d = LOAD;
        end
      end
      FLUSH: begin
        busy_o  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Read data arrives one cycle after issue; only the first mismatch address is kept.
  always_comb begin
    rd_pending_d = mem_en_o && !mem_we_o;
    rd_exp_d     = {DATA_W{op_bg}};
    rd_addr_d    = addr_i;
    fail_d       = fail_q;
    fail_addr_d  = fail_addr_q;
    if (accept) begin
      fail_d      = 1'b0;
      fail_addr_d = '0;
    end else if (rd_pending_q && (mem_rdata_i != rd_exp_q) && !fail_q) begin
      fail_d      = 1'b1;
      fail_addr_d = rd_addr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      elem_q       <= 3'd0;
      rd_pending_q <= 1'b0;
      rd_exp_q     <= '0;
      rd_addr_q    <= '0;
      fail_q       <= 1'b0;
      fail_addr_q  <= '0;
    end else begin
      state_q      <= state_d;
      elem_q       <= elem_d;
      rd_pending_q <= rd_pending_d;
      rd_exp_q     <= rd_exp_d;
      rd_addr_q    <= rd_addr_d;
      fail_q       <= fail_d;
      fail_addr_q  <= fail_addr_d;
    end
  end

  assign fail_o      = fail_q;
  assign fail_addr_o = fail_addr_q;

endmodule

// File: tb/tb_march_ctrl.sv
// Scoreboard bench for march_ctrl: a 4-word DUT with counter/memory models and fault
// injection, plus a 1024-word instance for the full-length counter handshake run.
module tb_march_ctrl;

  localparam int N  = 4;
  localparam int BN = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Small instance (ADDR_W = 2)
  logic       start, ld, cen, ud, men, mwe, busy, done, fail;
  logic [1:0] addr, din, faddr;
  logic [7:0] rdata, mwd;
  logic [7:0] mem [N];
  int         faultMode;

  // Large instance (ADDR_W = 10)
  logic       start2, ld2, cen2, ud2, men2, mwe2, busy2, done2, fail2;
  logic [9:0] addr2, din2, faddr2;
  logic [7:0] rdata2, mwd2;
  logic [7:0] mem2 [BN];
  int         busy2Cyc, ldViol, wrapViol;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         cycles;
    logic       fail;
    logic [1:0] fa;
    int         fcyc;
  } result_t;

  logic [10:0] accessQ[$];
  result_t     resultQ[$];

  int   runCyc = 0;
  int   failCyc = 0;
  logic busyPrev = 1'b0;
  logic donePrev = 1'b0;

  bit elemUp [6]     = '{1, 1, 1, 0, 0, 1};
  int elemOps [6]    = '{1, 2, 2, 2, 2, 1};
  bit opWe [6][2]    = '{'{1, 0}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 1}, '{0, 0}};
  bit opBg [6][2]    = '{'{0, 0}, '{0, 1}, '{1, 0}, '{0, 1}, '{1, 0}, '{0, 0}};

  logic [19:0] outs;
  assign outs = {ld, cen, ud, din, men, mwe, mwd, busy, done, fail, faddr};

  march_ctrl #(.ADDR_W(2), .DATA_W(8)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .addr_i(addr), .mem_rdata_i(rdata),
    .ld_o(ld), .cen_o(cen), .u_d_o(ud), .d_in_o(din), .mem_en_o(men), .mem_we_o(mwe),
    .mem_wdata_o(mwd), .busy_o(busy), .done_o(done), .fail_o(fail), .fail_addr_o(faddr)
  );

  march_ctrl #(.ADDR_W(10), .DATA_W(8)) dutBig (
    .clk_i(clk), .rst_i(rst), .start_i(start2), .addr_i(addr2), .mem_rdata_i(rdata2),
    .ld_o(ld2), .cen_o(cen2), .u_d_o(ud2), .d_in_o(din2), .mem_en_o(men2), .mem_we_o(mwe2),
    .mem_wdata_o(mwd2), .busy_o(busy2), .done_o(done2), .fail_o(fail2), .fail_addr_o(faddr2)
  );

  function automatic logic [7:0] readFault(input logic [1:0] a, input logic [7:0] v);
    if (faultMode == 1 && a == 2'd2) return v | 8'h01;
    if (faultMode == 2 && a == 2'd3) return 8'h00;
    return v;
  endfunction

  // Address counter and synchronous-read memory models for the small instance.
  always @(posedge clk or posedge rst) begin
    if (rst) addr <= '0;
    else if (cen) addr <= ld ? din : (ud ? addr + 2'd1 : addr - 2'd1);
  end

  always @(posedge clk) begin
    if (men) begin
      if (mwe) mem[addr] <= mwd;
      else rdata <= readFault(addr, mem[addr]);
    end
  end

  // Same models for the large instance; a step past either end counts as a wrap.
  always @(posedge clk or posedge rst) begin
    if (rst) addr2 <= '0;
    else if (cen2) begin
      if (!ld2 && ((ud2 && addr2 == 10'h3FF) || (!ud2 && addr2 == 10'h000)))
        wrapViol <= wrapViol + 1;
      addr2 <= ld2 ? din2 : (ud2 ? addr2 + 10'd1 : addr2 - 10'd1);
    end
  end

  always @(posedge clk) begin
    if (men2) begin
      if (mwe2) mem2[addr2] <= mwd2;
      else rdata2 <= mem2[addr2];
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected access per memory cycle and one result per rising done.
  always @(negedge clk) begin
    logic [10:0] expAcc;
    result_t     r;
    if (busy && !busyPrev) begin
      runCyc  = 0;
      failCyc = 0;
    end
    if (busy) runCyc++;
    if (busy && fail && failCyc == 0) failCyc = runCyc;
    if (men) begin
      if (accessQ.size() == 0) begin
        checkOutput("accessUnexpected", 32'({mwe, addr, mwd}), 32'hFFFF_FFFF);
      end else begin
        expAcc = accessQ.pop_front();
        checkOutput("access", 32'({mwe, addr, mwd}), 32'(expAcc));
      end
    end
    if (done && !donePrev) begin
      if (resultQ.size() == 0) begin
        checkOutput("doneUnexpected", 32'(done), 32'd0);
      end else begin
        r = resultQ.pop_front();
        checkOutput("busyCycles", 32'(runCyc), 32'(r.cycles));
        checkOutput("failFlag", 32'(fail), 32'(r.fail));
        checkOutput("failAddr", 32'(faddr), 32'(r.fa));
        checkOutput("failCycle", 32'(failCyc), 32'(r.fcyc));
        checkOutput("doneAfterBusy", 32'(busyPrev), 32'd1);
      end
    end
    busyPrev = busy;
    donePrev = done;
  end

  always @(negedge clk) begin
    if (busy2) busy2Cyc++;
    if (ld2 && !cen2) ldViol++;
  end

  task automatic pushMarch();
    int a;
    logic [1:0] a2;
    for (int e = 0; e < 6; e++)
      for (int k = 0; k < N; k++) begin
        a  = elemUp[e] ? k : N - 1 - k;
        a2 = a[1:0];
        for (int op = 0; op < elemOps[e]; op++)
          accessQ.push_back({opWe[e][op], a2, opWe[e][op] ? {8{opBg[e][op]}} : 8'h00});
      end
  endtask

  task automatic pulseStart();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic applyStimulus(input int mode, input logic expFail, input logic [1:0] expFa,
                               input int expFcyc);
    result_t r;
    faultMode = mode;
    pushMarch();
    r.cycles = 6 + 10 * N + 1;
    r.fail   = expFail;
    r.fa     = expFa;
    r.fcyc   = expFcyc;
    resultQ.push_back(r);
    pulseStart();
  endtask

  task automatic waitDone(input string name, input int bound);
    for (int i = 0; i < bound; i++) begin
      @(negedge clk); #1;
      if (done) return;
    end
    checkOutput(name, 32'(done), 32'd1);
  endtask

  task automatic waitRunCyc(input int target);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk); #1;
      if (runCyc >= target) return;
    end
    checkOutput("runCycTimeout", 32'(runCyc), 32'(target));
  endtask

  initial begin
    start = 1'b0; start2 = 1'b0; faultMode = 0;
    busy2Cyc = 0; ldViol = 0; wrapViol = 0;

    repeat (2) @(posedge clk);
    #1 checkOutput("resetOutputs", 32'(outs), 32'd0);
    rst = 1'b0;

    repeat (20) @(posedge clk);
    #1 checkOutput("idleOutputs", 32'(outs), 32'd0);
    checkOutput("idleBusyBig", 32'(busy2), 32'd0);

    $display("[TB] fault-free run");
    applyStimulus(0, 1'b0, 2'd0, 0);
    waitDone("doneTimeoutClean", 60);
    checkOutput("accessDrainedClean", 32'(accessQ.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1 checkOutput("doneLevel", 32'(done), 32'd1);

    $display("[TB] stuck-at-1 bit0 at address 2");
    applyStimulus(1, 1'b1, 2'd2, 13);
    waitDone("doneTimeoutSa1", 60);
    checkOutput("accessDrainedSa1", 32'(accessQ.size()), 32'd0);

    $display("[TB] stuck-at-0 at address 3");
    applyStimulus(2, 1'b1, 2'd3, 24);
    checkOutput("startClears", 32'({done, fail, faddr}), 32'd0);
    waitDone("doneTimeoutSa0", 60);
    checkOutput("accessDrainedSa0", 32'(accessQ.size()), 32'd0);

    $display("[TB] ignored start, then reset in E3");
    faultMode = 0;
    pushMarch();
    pulseStart();
    waitRunCyc(10);
    pulseStart();
    waitRunCyc(28);
    #1 rst = 1'b1;
    #1 checkOutput("midResetOutputs", 32'(outs), 32'd0);
    accessQ.delete();
    resultQ.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 checkOutput("postResetIdle", 32'(outs), 32'd0);

    applyStimulus(0, 1'b0, 2'd0, 0);
    waitDone("doneTimeoutAfterReset", 60);
    checkOutput("accessDrainedAfterReset", 32'(accessQ.size()), 32'd0);

    $display("[TB] 1024-word counter handshake run");
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int i = 0; i < 11000 && !done2; i++) begin
      @(negedge clk); #1;
    end
    checkOutput("bigDone", 32'(done2), 32'd1);
    checkOutput("bigBusyCycles", 32'(busy2Cyc), 32'd10247);
    checkOutput("bigFail", 32'(fail2), 32'd0);
    checkOutput("bigLdWithoutCen", 32'(ldViol), 32'd0);
    checkOutput("bigWrap", 32'(wrapViol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
